atm_dispensador: RTL
====================

Name: atm_dispensador

Overview:
- Cash-dispense sequencer driven by the ATM transaction controller's entregar_dinero/monto.
- Plans a bill mix from four internal cassettes (10000, 5000, 2000, 1000), then drives the mechanical dispenser one bill at a time with a req/ack handshake.
- Reports completion, planning failure (cannot compose amount) or mechanical timeout, and tracks cassette inventory.

Parameters:
CASS_INIT, 10, bills per cassette after reset/reload
CNT_W, 8, cassette counter width
MAX_BILLETES, 40, max bills per request
ACK_TIMEOUT, 16, cycles to wait for billete_ack before fault
LOW_MARK, 3, cassette count below which nivel_bajo bit is set

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
entregar_dinero  in  1  request pulse; samples monto
monto  in  32  amount in colones
recarga  in  1  restore all cassettes to CASS_INIT
billete_ack  in  1  dispenser accepted one bill
billete_req  out  1  dispense one bill
billete_denom  out  2  0=10000, 1=5000, 2=2000, 3=1000
listo  out  1  idle, accepting requests
entrega_ok  out  1  1-cycle pulse, full amount dispensed
sin_billetes  out  1  1-cycle pulse, amount not composable
falla_mecanica  out  1  1-cycle pulse, ack timeout
monto_entregado  out  32  amount dispensed for current/last request
nivel_bajo  out  4  bit d set when cassette d count < LOW_MARK

Behaviour:
- Reset (async): state IDLE; all cassettes=CASS_INIT; plan counts, monto_entregado, all pulses, billete_req, billete_denom = 0; listo=1; nivel_bajo per CASS_INIT.
- IDLE: listo=1. entregar_dinero=1 → latch monto into rem, clear plan counts, bill total and monto_entregado → PLAN. recarga in IDLE (without entregar_dinero) → cassettes=CASS_INIT next cycle. If both are high, entregar_dinero wins; recarga is ignored. Both inputs are ignored outside IDLE.
- PLAN: one bill planned per cycle, greedy. Pick the largest d with value(d) <= rem and plan[d] < cassette[d]; rem -= value(d); plan[d]++; total++.
  - rem==0 → DISPENSE (monto=0 goes DISPENSE→DONE with no bills).
  - No eligible d, or total==MAX_BILLETES with rem!=0 → ERR.
  - Greedy failure is the defined error. No backtracking; cassettes untouched.
- ERR: sin_billetes=1 for one cycle → IDLE.
- DISPENSE: serve d=0..3 in order while plan[d]>0.
  - Assert billete_req with billete_denom=d; hold both stable until ack.
  - Ack in the same cycle as req high: plan[d]--, cassette[d]--, monto_entregado += value(d), deassert req the next cycle for ≥1 cycle.
  - All plan zero → DONE.
  - Timeout counter clears at each req assertion. Reaching ACK_TIMEOUT cycles without ack → FAULT.
- DONE: entrega_ok=1 one cycle → IDLE.
- FAULT: falla_mecanica=1 one cycle, req=0. Keep monto_entregado (partial amount) and remaining plan discarded → IDLE.
- billete_ack while req=0 is ignored.
- Cassette counters never underflow, guaranteed by the plan bound.
- Reset mid-operation aborts immediately: no pulse, cassettes restored to CASS_INIT.
- monto_entregado is 32-bit; no overflow is possible within MAX_BILLETES×10000.
- Latency: request→first req = bills planned + 2 cycles.

Decomposition:
- Shared package atm_pkg: denomination encoding (D_10000..D_1000), value table, state encoding (IDLE, PLAN, ERR, DISPENSE, DONE, FAULT).
- Sub-module atm_cassette: one per denomination. Holds the count with load/decrement and the nivel_bajo compare; instantiated 4×.

Test Plan:
- CASS_INIT=10, monto=18000, ack 2 cycles after each req → reqs with denom 0,1,2,3; entrega_ok; monto_entregado=18000; each cassette=9.
- monto=10500 → sin_billetes pulse; no billete_req; cassettes unchanged; listo back to 1.
- monto=120000 → 10×denom0 then 4×denom1; nivel_bajo[0]=1. Then monto=10000 → 2×denom1 (cassette0 empty), entrega_ok.
- monto=5000, billete_ack never asserted → falla_mecanica exactly ACK_TIMEOUT cycles after req rises; monto_entregado=0; cassette1 unchanged.
- monto=30000, rst asserted after first ack → all outputs 0, listo=1, cassettes=10 asynchronously; no entrega_ok.
- monto=500000 (needs 50 bills > MAX_BILLETES=40) → sin_billetes. recarga pulse during DISPENSE is ignored; recarga in IDLE restores counts to 10.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared types and helpers for the cash-dispense sequencer.
//   denom_e    : cassette/denomination encoding, also driven on billete_denom
//   state_e    : sequencer states
//   denom_value: face value in colones for a denomination code
package atm_pkg;

  localparam int unsigned NUM_DENOM = 4;

  typedef enum logic [1:0] {
    D_10000 = 2'd0,
    D_5000  = 2'd1,
    D_2000  = 2'd2,
    D_1000  = 2'd3
  } denom_e;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    ERR,
    DISPENSE,
    DONE,
    FAULT
  } state_e;

  function automatic logic [31:0] denom_value(input logic [1:0] d);
    logic [31:0] v;
    case (d)
      D_10000: v = 32'd10000;
      D_5000:  v = 32'd5000;
      D_2000:  v = 32'd2000;
      default: v = 32'd1000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/atm_cassette.sv
// atm_cassette: bill inventory for one denomination.
//   clk, rst : clock, asynchronous active-high reset (count -> CASS_INIT)
//   load     : restore count to CASS_INIT
//   dec      : one bill left the cassette
//   count    : bills currently held
//   low      : count below LOW_MARK
module atm_cassette
  import atm_pkg::*;
#(
  parameter int unsigned CASS_INIT = 10,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LOW_MARK  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             low
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(CASS_INIT);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_W'(CASS_INIT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign low   = (count_q < CNT_W'(LOW_MARK));

endmodule

// File: rtl/atm_dispensador.sv
// atm_dispensador: plans a greedy bill mix for a requested amount and feeds the
// mechanical dispenser one bill at a time over a req/ack handshake.
//   entregar_dinero/monto : request pulse and amount (sampled in IDLE only)
//   recarga               : refill all cassettes (IDLE only)
//   billete_req/_denom/_ack : per-bill handshake with the dispenser
//   listo                 : idle
//   entrega_ok / sin_billetes / falla_mecanica : one-cycle outcome pulses
//   monto_entregado       : amount physically dispensed for current/last request
//   nivel_bajo            : per-cassette low-inventory flags
module atm_dispensador
  import atm_pkg::*;
#(
  parameter int unsigned CASS_INIT    = 10,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MAX_BILLETES = 40,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned LOW_MARK     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entregar_dinero,
  input  logic [31:0] monto,
  input  logic        recarga,
  input  logic        billete_ack,
  output logic        billete_req,
  output logic [1:0]  billete_denom,
  output logic        listo,
  output logic        entrega_ok,
  output logic        sin_billetes,
  output logic        falla_mecanica,
  output logic [31:0] monto_entregado,
  output logic [3:0]  nivel_bajo
);

  localparam int unsigned TOT_W = $clog2(MAX_BILLETES + 1);
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [31:0]      rem_q, rem_d;
  logic [CNT_W-1:0] plan_q [NUM_DENOM];
  logic [CNT_W-1:0] plan_d [NUM_DENOM];
  logic [TOT_W-1:0] total_q, total_d;
  logic [31:0]      entregado_q, entregado_d;
  logic             req_q, req_d;
  logic [1:0]       denom_q, denom_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [CNT_W-1:0] cass_cnt [NUM_DENOM];
  logic [3:0]       cass_dec;
  logic             cass_load;

  logic             pick_ok, serve_ok;
  logic [1:0]       pick_d, serve_d;

  for (genvar g = 0; g < NUM_DENOM; g++) begin : g_cass
    atm_cassette #(
      .CASS_INIT(CASS_INIT),
      .CNT_W    (CNT_W),
      .LOW_MARK (LOW_MARK)
    ) u_cass (
      .clk  (clk),
      .rst  (rst),
      .load (cass_load),
      .dec  (cass_dec[g]),
      .count(cass_cnt[g]),
      .low  (nivel_bajo[g])
    );
  end

  // Largest denomination that still fits the remainder and has stock not yet
  // reserved by the plan; and the first denomination with bills left to serve.
  always_comb begin
    pick_ok  = 1'b0;
    pick_d   = '0;
    serve_ok = 1'b0;
    serve_d  = '0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (!pick_ok && (denom_value(2'(i)) <= rem_q) && (plan_q[i] < cass_cnt[i])) begin
        pick_ok = 1'b1;
        pick_d  = 2'(i);
      end
      if (!serve_ok && (plan_q[i] != '0)) begin
        serve_ok = 1'b1;
        serve_d  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    plan_d      = plan_q;
    total_d     = total_q;
    entregado_d = entregado_q;
    req_d       = req_q;
    denom_d     = denom_q;
    tmo_d       = tmo_q;
    cass_dec    = '0;
    cass_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (entregar_dinero) begin
          rem_d       = monto;
          plan_d      = '{default: '0};
          total_d     = '0;
          entregado_d = '0;
          state_d     = PLAN;
        end else if (recarga) begin
          cass_load = 1'b1;
        end
      end

      PLAN: begin
        if (rem_q == '0) begin
          state_d = DISPENSE;
        end else if ((total_q == TOT_W'(MAX_BILLETES)) || !pick_ok) begin
          state_d = ERR;
        end else begin
          rem_d          = rem_q - denom_value(pick_d);
          plan_d[pick_d] = plan_q[pick_d] + 1'b1;
          total_d        = total_q + 1'b1;
        end
      end

      ERR: state_d = IDLE;

      DISPENSE: begin
        if (req_q) begin
          if (billete_ack) begin
            plan_d[denom_q]   = plan_q[denom_q] - 1'b1;
            cass_dec[denom_q] = 1'b1;
            entregado_d       = entregado_q + denom_value(denom_q);
            req_d             = 1'b0;
          end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            req_d   = 1'b0;
            state_d = FAULT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (serve_ok) begin
          req_d   = 1'b1;
          denom_d = serve_d;
          tmo_d   = '0;
        end else begin
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      FAULT: begin
        plan_d  = '{default: '0};
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      plan_q      <= '{default: '0};
      total_q     <= '0;
      entregado_q <= '0;
      req_q       <= 1'b0;
      denom_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      plan_q      <= plan_d;
      total_q     <= total_d;
      entregado_q <= entregado_d;
      req_q       <= req_d;
      denom_q     <= denom_d;
      tmo_q       <= tmo_d;
    end
  end

  assign billete_req     = req_q;
  assign billete_denom   = denom_q;
  assign listo           = (state_q == IDLE);
  assign entrega_ok      = (state_q == DONE);
  assign sin_billetes    = (state_q == ERR);
  assign falla_mecanica  = (state_q == FAULT);
  assign monto_entregado = entregado_q;

endmodule
